// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, FSM states,
// mux selects and the control-word layout driven onto the datapath.
package mc_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_OUT  = 6'h3D;
    localparam logic [5:0] OP_IN   = 6'h3E;
    localparam logic [5:0] OP_HALT = 6'h3F;
    localparam logic [5:0] FN_JR   = 6'h08;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_BNE   = 3'b011;

    localparam logic [1:0] RDST_RT  = 2'b00;
    localparam logic [1:0] RDST_RD  = 2'b01;
    localparam logic [1:0] RDST_RA  = 2'b10;
    localparam logic [1:0] RDST_R28 = 2'b11;

    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_MDR  = 2'b01;
    localparam logic [1:0] M2R_PC   = 2'b10;
    localparam logic [1:0] M2R_USER = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    typedef enum logic [4:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_R_WB, ST_EXEC_JR, ST_EXEC_I, ST_I_WB,
        ST_MEM_ADDR, ST_MEM_READ, ST_MEM_WB, ST_MEM_WRITE, ST_BRANCH, ST_JUMP,
        ST_OUT, ST_IN_WAIT, ST_IN_WB, ST_HALT
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       input_flag;
        logic       output_flag;
        logic       halt;
        logic       retire;
        logic       illegal;
    } ctrl_word_t;

    function automatic logic opcode_legal(input logic [5:0] op, input logic io_en);
        case (op)
            OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI,
            OP_LW, OP_SW, OP_HALT: return 1'b1;
            OP_OUT, OP_IN:         return io_en;
            default:               return 1'b0;
        endcase
    endfunction

    // States that touch the shared memory and therefore honour the wait counter.
    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath/IO bundle: IR fields and flags in, control word out.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       insert;

    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       input_flag;
    logic       output_flag;
    logic       halt;
    logic       retire;
    logic       illegal;

    modport master (
        input  opcode, funct, zero, insert,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, input_flag, output_flag, halt, retire, illegal
    );

    modport slave (
        output opcode, funct, zero, insert,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, input_flag, output_flag, halt, retire, illegal
    );
endinterface

// File: rtl/mc_output_decode.sv
// Combinational state -> control-word decode. Memory-state strobes that must
// fire once (ir_write, pc_write, MEM_WRITE retire) are qualified by last_wait.
module mc_output_decode
    import mc_pkg::*;
#(
    parameter bit IO_ENABLE = 1'b1
) (
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       last_wait,
    input  logic       first_cycle,
    output ctrl_word_t cw
);

    always_comb begin
        cw = '0;
        case (state)
            ST_FETCH: begin
                cw.mem_read  = 1'b1;
                cw.alu_src_a = 1'b0;
                cw.alu_src_b = SRCB_FOUR;
                cw.alu_op    = ALU_ADD;
                cw.pc_source = PCSRC_ALU;
                cw.ir_write  = last_wait;
                cw.pc_write  = last_wait;
            end
            ST_DECODE: begin
                cw.alu_src_b = SRCB_IMMSL2;
                cw.alu_op    = ALU_ADD;
                cw.illegal   = !opcode_legal(opcode, IO_ENABLE);
            end
            ST_EXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_B;
                cw.alu_op    = ALU_RTYPE;
            end
            ST_R_WB: begin
                cw.reg_dst   = RDST_RD;
                cw.reg_write = 1'b1;
                cw.retire    = 1'b1;
            end
            ST_EXEC_JR: begin
                cw.pc_source = PCSRC_REG;
                cw.pc_write  = 1'b1;
                cw.retire    = 1'b1;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALU_ADD;
            end
            ST_I_WB: begin
                cw.reg_dst   = RDST_RT;
                cw.reg_write = 1'b1;
                cw.retire    = 1'b1;
            end
            ST_MEM_READ: begin
                cw.i_or_d   = 1'b1;
                cw.mem_read = 1'b1;
            end
            ST_MEM_WB: begin
                cw.mem_to_reg = M2R_MDR;
                cw.reg_dst    = RDST_RT;
                cw.reg_write  = 1'b1;
                cw.retire     = 1'b1;
            end
            ST_MEM_WRITE: begin
                cw.i_or_d    = 1'b1;
                cw.mem_write = 1'b1;
                cw.retire    = last_wait;
            end
            ST_BRANCH: begin
                cw.alu_src_a     = 1'b1;
                cw.alu_src_b     = SRCB_B;
                cw.alu_op        = (opcode == OP_BNE) ? ALU_BNE : ALU_SUB;
                cw.pc_source     = PCSRC_ALUOUT;
                cw.pc_write_cond = 1'b1;
                cw.retire        = 1'b1;
            end
            ST_JUMP: begin
                cw.pc_source = PCSRC_JUMP;
                cw.pc_write  = 1'b1;
                cw.retire    = 1'b1;
                if (opcode == OP_JAL) begin
                    cw.reg_dst    = RDST_RA;
                    cw.mem_to_reg = M2R_PC;
                    cw.reg_write  = 1'b1;
                end
            end
            ST_OUT: begin
                cw.output_flag = 1'b1;
                cw.retire      = 1'b1;
            end
            ST_IN_WAIT: cw.input_flag = 1'b1;
            ST_IN_WB: begin
                cw.reg_dst    = RDST_R28;
                cw.mem_to_reg = M2R_USER;
                cw.reg_write  = 1'b1;
                cw.retire     = 1'b1;
            end
            ST_HALT: begin
                cw.halt   = 1'b1;
                cw.retire = first_cycle;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: state register, memory wait counter and
// insert edge detector; the control word comes from mc_output_decode.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int unsigned MEM_WAIT  = 0,
    parameter bit          IO_ENABLE = 1'b1
) (
    input logic                  CLK,
    input logic                  reset,
    multicycle_control_if.master bus
);

    localparam logic [3:0] WAIT_LAST = MEM_WAIT[3:0];

    state_t     state_q, state_d;
    logic [3:0] wait_cnt;
    logic       insert_q;
    logic       last_wait, first_cycle, ins_rise;
    ctrl_word_t cw, cw_out;

    assign last_wait   = (wait_cnt == WAIT_LAST);
    assign first_cycle = (wait_cnt == 4'd0);
    assign ins_rise    = bus.insert & ~insert_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            wait_cnt <= 4'd0;
            insert_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            insert_q <= bus.insert;
            // HALT reuses the counter as a one-shot marker for its single retire.
            if (state_d != state_q)
                wait_cnt <= 4'd0;
            else if ((is_mem_state(state_q) && !last_wait) ||
                     (state_q == ST_HALT && first_cycle))
                wait_cnt <= wait_cnt + 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:     if (last_wait) state_d = ST_DECODE;
            ST_DECODE: begin
                if (!opcode_legal(bus.opcode, IO_ENABLE)) begin
                    state_d = ST_FETCH;
                end else begin
                    case (bus.opcode)
                        OP_R:           state_d = (bus.funct == FN_JR) ? ST_EXEC_JR : ST_EXEC;
                        OP_J, OP_JAL:   state_d = ST_JUMP;
                        OP_BEQ, OP_BNE: state_d = ST_BRANCH;
                        OP_ADDI:        state_d = ST_EXEC_I;
                        OP_LW, OP_SW:   state_d = ST_MEM_ADDR;
                        OP_OUT:         state_d = ST_OUT;
                        OP_IN:          state_d = ST_IN_WAIT;
                        OP_HALT:        state_d = ST_HALT;
                        default:        state_d = ST_FETCH;
                    endcase
                end
            end
            ST_EXEC:      state_d = ST_R_WB;
            ST_EXEC_I:    state_d = ST_I_WB;
            ST_MEM_ADDR:  state_d = (bus.opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ:  if (last_wait) state_d = ST_MEM_WB;
            ST_MEM_WRITE: if (last_wait) state_d = ST_FETCH;
            ST_IN_WAIT:   if (ins_rise) state_d = ST_IN_WB;
            ST_HALT:      state_d = ST_HALT;
            ST_R_WB, ST_EXEC_JR, ST_I_WB, ST_MEM_WB,
            ST_BRANCH, ST_JUMP, ST_OUT, ST_IN_WB: state_d = ST_FETCH;
            default:      state_d = ST_FETCH;
        endcase
    end

    mc_output_decode #(.IO_ENABLE(IO_ENABLE)) u_decode (
        .state       (state_q),
        .opcode      (bus.opcode),
        .last_wait   (last_wait),
        .first_cycle (first_cycle),
        .cw          (cw)
    );

    // Reset cycle must present an all-zero control word regardless of state.
    assign cw_out = reset ? '0 : cw;

    assign bus.pc_write      = cw_out.pc_write;
    assign bus.pc_write_cond = cw_out.pc_write_cond;
    assign bus.i_or_d        = cw_out.i_or_d;
    assign bus.mem_read      = cw_out.mem_read;
    assign bus.mem_write     = cw_out.mem_write;
    assign bus.ir_write      = cw_out.ir_write;
    assign bus.reg_dst       = cw_out.reg_dst;
    assign bus.mem_to_reg    = cw_out.mem_to_reg;
    assign bus.reg_write     = cw_out.reg_write;
    assign bus.alu_src_a     = cw_out.alu_src_a;
    assign bus.alu_src_b     = cw_out.alu_src_b;
    assign bus.alu_op        = cw_out.alu_op;
    assign bus.pc_source     = cw_out.pc_source;
    assign bus.input_flag    = cw_out.input_flag;
    assign bus.output_flag   = cw_out.output_flag;
    assign bus.halt          = cw_out.halt;
    assign bus.retire        = cw_out.retire;
    assign bus.illegal       = cw_out.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: one instance with no memory wait, one with MEM_WAIT=2 and IO disabled.
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic       reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       input_flag, output_flag, halt, retire, illegal;
    } obs_t;

    typedef struct {
        logic [5:0] op, fn;
        logic       z;
        int         lat;
        logic [1:0] rdst, m2r, psrc;
        logic [2:0] aop;
        logic       rw, pw, pwc, mw, of;
        int         n_rd;
    } vec_t;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0, funct = '0;
    logic       zero = 1'b0, insert = 1'b0;

    int n_vec = 0, n_err = 0;
    int ret_cyc, n_rw, n_ir, n_rd, n_pw, n_wr, n_iod, n_inf, ir_at;
    obs_t trace [32];
    vec_t vt [11];

    multicycle_control_if if0 ();
    multicycle_control_if if2 ();

    assign if0.opcode = opcode;
    assign if0.funct  = funct;
    assign if0.zero   = zero;
    assign if0.insert = insert;
    assign if2.opcode = opcode;
    assign if2.funct  = funct;
    assign if2.zero   = zero;
    assign if2.insert = insert;

    multicycle_control #(.MEM_WAIT(0), .IO_ENABLE(1'b1)) dut0 (.CLK(CLK), .reset(reset), .bus(if0));
    multicycle_control #(.MEM_WAIT(2), .IO_ENABLE(1'b0)) dut2 (.CLK(CLK), .reset(reset), .bus(if2));

    always #5 CLK = ~CLK;

    function automatic obs_t grab(input int sel);
        obs_t o;
        if (sel == 0)
            o = {if0.pc_write, if0.pc_write_cond, if0.i_or_d, if0.mem_read, if0.mem_write,
                 if0.ir_write, if0.reg_dst, if0.mem_to_reg, if0.reg_write, if0.alu_src_a,
                 if0.alu_src_b, if0.alu_op, if0.pc_source, if0.input_flag, if0.output_flag,
                 if0.halt, if0.retire, if0.illegal};
        else
            o = {if2.pc_write, if2.pc_write_cond, if2.i_or_d, if2.mem_read, if2.mem_write,
                 if2.ir_write, if2.reg_dst, if2.mem_to_reg, if2.reg_write, if2.alu_src_a,
                 if2.alu_src_b, if2.alu_op, if2.pc_source, if2.input_flag, if2.output_flag,
                 if2.halt, if2.retire, if2.illegal};
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        @(negedge CLK);
        chk("reset_out_w0", grab(0), 0);
        chk("reset_out_w2", grab(2), 0);
    endtask

    // Runs from FETCH until the first retire or max_c cycles, tallying strobes.
    task automatic run_vec(input int sel, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int max_c);
        obs_t o;
        ret_cyc = 0; n_rw = 0; n_ir = 0; n_rd = 0; n_pw = 0; n_wr = 0; n_iod = 0; n_inf = 0;
        ir_at = 0;
        trace[0] = '0;
        for (int c = 1; c <= max_c; c++) begin
            tick();
            if (c == 1) begin
                reset = 1'b0; opcode = op; funct = fn; zero = z;
            end
            @(negedge CLK);
            o = grab(sel);
            trace[c] = o;
            n_rw  += int'(o.reg_write);
            n_ir  += int'(o.ir_write);
            n_rd  += int'(o.mem_read);
            n_pw  += int'(o.pc_write);
            n_wr  += int'(o.mem_write);
            n_iod += int'(o.i_or_d);
            n_inf += int'(o.input_flag);
            if (o.ir_write) ir_at = c;
            if (o.retire) begin
                ret_cyc = c;
                break;
            end
        end
    endtask

    initial begin
        obs_t r, o;
        int   nh, nr, en;

        //          op     fn     z     lat rdst   m2r    psrc   aop     rw    pw    pwc   mw    of  n_rd
        vt[0]  = '{6'h00, 6'h20, 1'b0, 4, 2'b01, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vt[1]  = '{6'h00, 6'h08, 1'b0, 3, 2'b00, 2'b00, 2'b11, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vt[2]  = '{6'h08, 6'h00, 1'b0, 4, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vt[3]  = '{6'h23, 6'h00, 1'b0, 5, 2'b00, 2'b01, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vt[4]  = '{6'h2B, 6'h00, 1'b0, 4, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vt[5]  = '{6'h04, 6'h00, 1'b1, 3, 2'b00, 2'b00, 2'b01, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vt[6]  = '{6'h04, 6'h00, 1'b0, 3, 2'b00, 2'b00, 2'b01, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vt[7]  = '{6'h05, 6'h00, 1'b1, 3, 2'b00, 2'b00, 2'b01, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vt[8]  = '{6'h02, 6'h00, 1'b0, 3, 2'b00, 2'b00, 2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vt[9]  = '{6'h03, 6'h00, 1'b0, 3, 2'b10, 2'b10, 2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vt[10] = '{6'h3D, 6'h00, 1'b0, 3, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1};

        // Back-to-back instruction stream on the zero-wait instance.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            run_vec(0, vt[i].op, vt[i].fn, vt[i].z, 8);
            r = trace[ret_cyc];
            if (i == 0)
                chk("fetch_after_reset", {trace[1].mem_read, trace[1].ir_write, trace[1].pc_write,
                    trace[1].alu_src_b}, {3'b111, 2'b01});
            chk($sformatf("v%0d_latency", i), ret_cyc, vt[i].lat);
            chk($sformatf("v%0d_retire_word", i),
                {r.reg_dst, r.mem_to_reg, r.pc_source, r.alu_op, r.reg_write, r.pc_write,
                 r.pc_write_cond, r.mem_write, r.output_flag},
                {vt[i].rdst, vt[i].m2r, vt[i].psrc, vt[i].aop, vt[i].rw, vt[i].pw,
                 vt[i].pwc, vt[i].mw, vt[i].of});
            chk($sformatf("v%0d_reg_write_cycles", i), n_rw, int'(vt[i].rw));
            chk($sformatf("v%0d_ir_write_cycles", i), n_ir, 1);
            chk($sformatf("v%0d_mem_read_cycles", i), n_rd, vt[i].n_rd);
            chk($sformatf("v%0d_pc_write_cycles", i), n_pw, 1 + int'(vt[i].pw));
        end

        // Wait states: LW then SW on the MEM_WAIT=2 instance.
        do_reset();
        run_vec(2, 6'h23, 6'h00, 1'b0, 20);
        chk("lw_w2_latency", ret_cyc, 9);
        chk("lw_w2_ir_write_cycles", n_ir, 1);
        chk("lw_w2_ir_write_at", ir_at, 3);
        chk("lw_w2_mem_read_cycles", n_rd, 6);
        chk("lw_w2_i_or_d_cycles", n_iod, 3);
        chk("lw_w2_reg_write_cycles", n_rw, 1);
        run_vec(2, 6'h2B, 6'h00, 1'b0, 20);
        chk("sw_w2_latency", ret_cyc, 8);
        chk("sw_w2_mem_write_cycles", n_wr, 3);
        chk("sw_w2_i_or_d_cycles", n_iod, 3);

        // OUT is illegal when IO is disabled.
        do_reset();
        run_vec(2, 6'h3D, 6'h00, 1'b0, 5);
        chk("out_noio_no_retire", ret_cyc, 0);
        chk("out_noio_illegal_pattern", {trace[3].illegal, trace[4].illegal, trace[5].illegal}, 3'b010);
        chk("out_noio_back_to_fetch", {trace[5].mem_read, trace[5].ir_write, trace[5].output_flag}, 3'b100);

        // Unknown opcode 0x11.
        do_reset();
        run_vec(0, 6'h11, 6'h00, 1'b0, 3);
        chk("ill_pattern", {trace[1].illegal, trace[2].illegal, trace[3].illegal}, 3'b010);
        chk("ill_refetch", {trace[3].mem_read, trace[3].ir_write}, 2'b11);
        chk("ill_no_retire", ret_cyc, 0);
        chk("ill_no_reg_write", n_rw, 0);

        // IN with insert already high on entry, then a real 0->1 edge.
        insert = 1'b1;
        do_reset();
        run_vec(0, 6'h3E, 6'h00, 1'b0, 8);
        chk("in_held_no_retire", ret_cyc, 0);
        chk("in_held_input_flag_cycles", n_inf, 6);
        chk("in_held_no_reg_write", n_rw, 0);
        tick(); insert = 1'b0;
        @(negedge CLK); o = grab(0);
        chk("in_low_wait", {o.input_flag, o.reg_write, o.retire}, 3'b100);
        tick(); insert = 1'b1;
        @(negedge CLK); o = grab(0);
        chk("in_edge_wait", {o.input_flag, o.reg_write, o.retire}, 3'b100);
        tick();
        @(negedge CLK); o = grab(0);
        chk("in_wb_word", {o.reg_dst, o.mem_to_reg, o.reg_write, o.retire, o.input_flag}, 7'b1111110);
        tick();
        @(negedge CLK); o = grab(0);
        chk("in_then_fetch", {o.mem_read, o.ir_write, o.input_flag}, 3'b110);
        insert = 1'b0;

        // HALT is sticky with a single retire, and reset releases it.
        do_reset();
        run_vec(0, 6'h3F, 6'h00, 1'b0, 5);
        chk("halt_latency", ret_cyc, 3);
        chk("halt_on_entry", trace[3].halt, 1'b1);
        nh = 0; nr = 0; en = 0;
        for (int c = 0; c < 7; c++) begin
            tick();
            @(negedge CLK); o = grab(0);
            nh += int'(o.halt);
            nr += int'(o.retire);
            en += int'(o.pc_write | o.pc_write_cond | o.mem_read | o.mem_write | o.ir_write | o.reg_write);
        end
        chk("halt_sticky_cycles", nh, 7);
        chk("halt_single_retire", nr, 0);
        chk("halt_enables_off", en, 0);
        tick(); reset = 1'b1;
        @(negedge CLK); o = grab(0);
        chk("halt_reset_cycle", o, 0);
        tick(); reset = 1'b0;
        @(negedge CLK); o = grab(0);
        chk("halt_reset_fetch", {o.halt, o.mem_read, o.ir_write}, 3'b011);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
